// File: rtl/param_loader_if.sv
// rtl/param_loader_if.sv - byte input, BRAM read ports and status bundle of the parameter loader
// Ports (slave = loader side):
//   rx_data/rx_ready  routed UART byte and its 1-cycle strobe
//   rearm             1-cycle pulse returning the loader to IDLE
//   w_rd_addr/data    weight read port (registered data)
//   b_rd_addr/data    bias read port (registered data)
//   busy/done/done_pulse/err/byte_cnt  transfer status
interface param_loader_if #(
    parameter int N_IN    = 784,
    parameter int N_OUT   = 10,
    parameter int W_BYTES = 1,
    parameter int B_BYTES = 4
);
    localparam int N_W     = N_IN * N_OUT;
    localparam int PAYLOAD = N_W * W_BYTES + N_OUT * B_BYTES;
    localparam int AW      = (N_W > 1) ? $clog2(N_W) : 1;
    localparam int BW      = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int CW      = $clog2(PAYLOAD + 1);

    logic [7:0]           rx_data;
    logic                 rx_ready;
    logic                 rearm;
    logic [AW-1:0]        w_rd_addr;
    logic [8*W_BYTES-1:0] w_rd_data;
    logic [BW-1:0]        b_rd_addr;
    logic [8*B_BYTES-1:0] b_rd_data;
    logic                 busy;
    logic                 done;
    logic                 done_pulse;
    logic [1:0]           err;
    logic [CW-1:0]        byte_cnt;

    modport master (
        output rx_data, rx_ready, rearm, w_rd_addr, b_rd_addr,
        input  w_rd_data, b_rd_data, busy, done, done_pulse, err, byte_cnt
    );

    modport slave (
        input  rx_data, rx_ready, rearm, w_rd_addr, b_rd_addr,
        output w_rd_data, b_rd_data, busy, done, done_pulse, err, byte_cnt
    );
endinterface

// File: rtl/param_loader.sv
// rtl/param_loader.sv - loads N_IN x N_OUT weights and N_OUT biases from a byte stream into BRAMs
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset (priority over rearm)
//   bus   param_loader_if slave: rx byte input, rearm, weight/bias read ports, status
// Stream: SKIP_FIRST discarded bytes, PAYLOAD bytes (weights then biases, little-endian),
// one checksum byte (8-bit sum of payload), then the tail 0x55 0xAA.
module param_loader #(
    parameter int N_IN        = 784,
    parameter int N_OUT       = 10,
    parameter int W_BYTES     = 1,
    parameter int B_BYTES     = 4,
    parameter int SKIP_FIRST  = 1,
    parameter int TIMEOUT_CYC = 1000000
) (
    input logic          clk,
    input logic          rst,
    param_loader_if.slave bus
);
    localparam int N_W     = N_IN * N_OUT;
    localparam int PAYLOAD = N_W * W_BYTES + N_OUT * B_BYTES;
    localparam int AW      = (N_W > 1) ? $clog2(N_W) : 1;
    localparam int BW      = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int CW      = $clog2(PAYLOAD + 1);
    localparam int SW      = (SKIP_FIRST > 0) ? $clog2(SKIP_FIRST + 1) : 1;
    localparam int TW      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_TAIL1 = 3'd3;
    localparam logic [2:0] S_TAIL2 = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;

    logic [2:0]           state;
    logic [CW-1:0]        byte_cnt;
    logic [SW-1:0]        skip_cnt;
    logic [7:0]           sum;
    logic [31:0]          shreg;
    logic [1:0]           part;      // byte position inside the current word
    logic                 in_bias;   // weights finished, now assembling biases
    logic [AW-1:0]        w_idx;
    logic [BW-1:0]        b_idx;
    logic [TW-1:0]        tcnt;
    logic [1:0]           err;
    logic                 done_pulse;

    logic [8*W_BYTES-1:0] w_mem [N_W];
    logic [8*B_BYTES-1:0] b_mem [N_OUT];
    logic [8*W_BYTES-1:0] w_q;
    logic [8*B_BYTES-1:0] b_q;

    logic        clear;
    logic        busy;
    logic        payload_byte;
    logic        last_w;
    logic        last_b;
    logic        timed_out;
    logic [31:0] word_next;

    assign clear        = rst | bus.rearm;
    assign busy         = state inside {S_LOAD, S_CHECK, S_TAIL1, S_TAIL2};
    assign payload_byte = !clear && bus.rx_ready &&
                          ((state == S_IDLE && skip_cnt == '0) || state == S_LOAD);
    // Bytes enter at the top, so an n-byte word ends up in the top n bytes.
    assign word_next    = {bus.rx_data, shreg[31:8]};
    assign last_w       = !in_bias && part == 2'(W_BYTES - 1);
    assign last_b       = in_bias && part == 2'(B_BYTES - 1);
    assign timed_out    = (TIMEOUT_CYC != 0) && busy && !bus.rx_ready &&
                          tcnt == TW'(TIMEOUT_CYC - 1);

    always_ff @(posedge clk) begin
        if (clear) begin
            state      <= S_IDLE;
            byte_cnt   <= '0;
            skip_cnt   <= SW'(SKIP_FIRST);
            sum        <= '0;
            shreg      <= '0;
            part       <= '0;
            in_bias    <= 1'b0;
            w_idx      <= '0;
            b_idx      <= '0;
            tcnt       <= '0;
            err        <= 2'b00;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            tcnt       <= (busy && !bus.rx_ready) ? tcnt + TW'(1) : '0;

            if (timed_out) begin
                err   <= 2'b11;
                state <= S_ERROR;
            end else if (bus.rx_ready) begin
                case (state)
                    S_IDLE: begin
                        if (skip_cnt != '0)
                            skip_cnt <= skip_cnt - SW'(1);
                    end
                    S_CHECK: begin
                        if (bus.rx_data == sum) begin
                            state <= S_TAIL1;
                        end else begin
                            err   <= 2'b01;
                            state <= S_ERROR;
                        end
                    end
                    S_TAIL1: begin
                        if (bus.rx_data == 8'h55) begin
                            state <= S_TAIL2;
                        end else begin
                            err   <= 2'b10;
                            state <= S_ERROR;
                        end
                    end
                    S_TAIL2: begin
                        if (bus.rx_data == 8'hAA) begin
                            state      <= S_DONE;
                            done_pulse <= 1'b1;
                        end else begin
                            err   <= 2'b10;
                            state <= S_ERROR;
                        end
                    end
                    default: ;
                endcase
            end

            if (payload_byte) begin
                sum      <= sum + bus.rx_data;
                shreg    <= word_next;
                byte_cnt <= byte_cnt + CW'(1);
                state    <= (byte_cnt == CW'(PAYLOAD - 1)) ? S_CHECK : S_LOAD;
                if (last_w) begin
                    part <= '0;
                    if (w_idx == AW'(N_W - 1))
                        in_bias <= 1'b1;
                    else
                        w_idx <= w_idx + AW'(1);
                end else if (last_b) begin
                    part  <= '0;
                    b_idx <= b_idx + BW'(1);
                end else begin
                    part <= part + 2'd1;
                end
            end
        end
    end

    // BRAMs: no reset; a same-cycle read of a written address returns the old word.
    always_ff @(posedge clk) begin
        if (payload_byte && last_w)
            w_mem[w_idx] <= word_next[31 -: 8*W_BYTES];
        if (payload_byte && last_b)
            b_mem[b_idx] <= word_next[31 -: 8*B_BYTES];
        w_q <= w_mem[bus.w_rd_addr];
        b_q <= b_mem[bus.b_rd_addr];
    end

    assign bus.w_rd_data  = w_q;
    assign bus.b_rd_data  = b_q;
    assign bus.busy       = busy;
    assign bus.done       = (state == S_DONE);
    assign bus.done_pulse = done_pulse;
    assign bus.err        = err;
    assign bus.byte_cnt   = byte_cnt;
endmodule

// File: tb/tb_param_loader.sv
// tb/tb_param_loader.sv - scoreboard bench for param_loader with a stream-level reference model
module tb_param_loader;
    localparam int N_IN = 4, N_OUT = 2, WB = 1, BB = 4, SKIP = 1, TMO = 100;
    localparam int N_W = N_IN * N_OUT, PAYLOAD = N_W * WB + N_OUT * BB;

    logic clk = 1'b0, rst = 1'b1, rst2 = 1'b1;
    always #5 clk = ~clk;

    param_loader_if #(.N_IN(N_IN), .N_OUT(N_OUT), .W_BYTES(WB), .B_BYTES(BB)) bus ();
    param_loader #(.N_IN(N_IN), .N_OUT(N_OUT), .W_BYTES(WB), .B_BYTES(BB),
                   .SKIP_FIRST(SKIP), .TIMEOUT_CYC(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    param_loader_if #(.N_IN(2), .N_OUT(2), .W_BYTES(2), .B_BYTES(2)) bus2 ();
    param_loader #(.N_IN(2), .N_OUT(2), .W_BYTES(2), .B_BYTES(2),
                   .SKIP_FIRST(1), .TIMEOUT_CYC(0)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    typedef struct { logic [1:0] code; int cnt; } ev_t;
    typedef struct { logic [7:0] w; logic [31:0] b; } rd_t;

    int errors = 0, checks = 0;
    ev_t ev_q[$];
    rd_t rd_q[$];
    ev_t e;
    rd_t r;
    logic [7:0]  wm [N_W];
    logic [31:0] bm [N_OUT];
    logic [7:0]  pay [PAYLOAD];
    logic [7:0]  mp [PAYLOAD];
    logic [7:0]  str[$];
    logic rd_req = 1'b0, rd_chk = 1'b0, mon_en = 1'b0;
    logic [1:0] prev_err = 2'b00;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: every completion event or read result pops one expectation.
    always @(posedge clk) rd_chk <= rd_req;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.done_pulse === 1'b1 || (bus.err !== 2'b00 && prev_err === 2'b00)) begin
                if (ev_q.size() == 0) begin
                    chk("unexpected_event_err", {bus.done_pulse, bus.err}, 3'b000);
                end else begin
                    e = ev_q.pop_front();
                    chk("event_err", bus.err, e.code);
                    chk("event_byte_cnt", bus.byte_cnt, e.cnt);
                    chk("event_done", bus.done, e.code == 2'b00);
                end
            end
            prev_err <= bus.err;
            if (rd_chk) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_read", 1, 0);
                end else begin
                    r = rd_q.pop_front();
                    chk("w_rd_data", bus.w_rd_data, r.w);
                    chk("b_rd_data", bus.b_rd_data, r.b);
                end
            end
        end
    end

    function automatic logic [31:0] le(input int base, input int nb);
        logic [31:0] v;
        v = '0;
        for (int j = 0; j < nb; j++) v = v | (32'(mp[base + j]) << (8 * j));
        return v;
    endfunction

    function automatic logic [7:0] psum();
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < PAYLOAD; i++) s = s + pay[i];
        return s;
    endfunction

    // Reference: interpret the whole byte stream by the transfer rules.
    task automatic model_push();
        int i, n;
        logic [7:0] sum;
        logic [7:0] tail[3];
        logic [1:0] bad[3];
        logic [1:0] code;
        bit decided;
        i = SKIP; n = 0; sum = '0;
        while (n < PAYLOAD && i < str.size()) begin
            mp[n] = str[i]; sum = sum + str[i]; n++; i++;
        end
        for (int w = 0; w < N_W; w++)
            if ((w + 1) * WB <= n) wm[w] = 8'(le(w * WB, WB));
        for (int k = 0; k < N_OUT; k++)
            if (N_W * WB + (k + 1) * BB <= n) bm[k] = le(N_W * WB + k * BB, BB);
        tail = '{sum, 8'h55, 8'hAA};
        bad  = '{2'd1, 2'd2, 2'd2};
        code = 2'd0; decided = 0;
        if (n < PAYLOAD) begin code = 2'd3; decided = 1; end
        for (int j = 0; j < 3; j++) begin
            if (!decided) begin
                if (i + j >= str.size()) begin code = 2'd3; decided = 1; end
                else if (str[i + j] != tail[j]) begin code = bad[j]; decided = 1; end
            end
        end
        ev_q.push_back(ev_t'{code, n});
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        bus.rx_data = b; bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b);
        bus2.rx_data = b; bus2.rx_ready = 1'b1;
        @(negedge clk);
        bus2.rx_ready = 1'b0;
    endtask

    task automatic mk_stream(input logic [7:0] ck, input logic [7:0] t1, input logic [7:0] t2);
        str.delete();
        str.push_back(8'($urandom));
        for (int i = 0; i < PAYLOAD; i++) str.push_back(pay[i]);
        str.push_back(ck); str.push_back(t1); str.push_back(t2);
    endtask

    task automatic rand_pay();
        for (int i = 0; i < PAYLOAD; i++) pay[i] = 8'($urandom_range(255, 0));
    endtask

    task automatic run();
        model_push();
        foreach (str[i]) send(str[i], $urandom_range(3, 0));
        repeat (3) @(negedge clk);
    endtask

    task automatic do_rearm(input bit with_byte);
        bus.rearm = 1'b1; bus.rx_ready = with_byte; bus.rx_data = 8'h55;
        @(negedge clk);
        bus.rearm = 1'b0; bus.rx_ready = 1'b0;
        chk("rearm_err", bus.err, 0);
        chk("rearm_done", bus.done, 0);
        chk("rearm_byte_cnt", bus.byte_cnt, 0);
        chk("rearm_busy", bus.busy, 0);
    endtask

    task automatic read_all();
        for (int a = 0; a < N_W; a++) begin
            bus.w_rd_addr = 3'(a); bus.b_rd_addr = 1'(a % N_OUT); rd_req = 1'b1;
            rd_q.push_back(rd_t'{wm[a], bm[a % N_OUT]});
            @(negedge clk);
        end
        rd_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wide();
        logic [7:0] p2[12];
        logic [7:0] s;
        p2 = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE, 8'h01, 8'h80, 8'hFF, 8'h7F};
        send2(8'h55); send2(8'h34); send2(8'h12);
        bus2.w_rd_addr = 2'd0;
        @(negedge clk);
        chk("w16_partial_read", bus2.w_rd_data, 16'h1234);
        chk("w16_busy_mid", bus2.busy, 1);
        chk("w16_byte_cnt_mid", bus2.byte_cnt, 2);
        rst2 = 1'b1; @(negedge clk); rst2 = 1'b0;
        chk("w16_rst_busy", bus2.busy, 0);
        chk("w16_rst_byte_cnt", bus2.byte_cnt, 0);
        chk("w16_rst_err", bus2.err, 0);
        s = '0;
        send2(8'hC3);
        for (int i = 0; i < 12; i++) begin
            s = s + p2[i];
            send2(p2[i]);
            if (i == 5) begin
                repeat (150) @(negedge clk);
                chk("w16_no_timeout_err", bus2.err, 0);
                chk("w16_no_timeout_busy", bus2.busy, 1);
            end
        end
        send2(s); send2(8'h55); send2(8'hAA);
        chk("w16_done", bus2.done, 1);
        chk("w16_err", bus2.err, 0);
        chk("w16_byte_cnt", bus2.byte_cnt, 12);
        bus2.w_rd_addr = 2'd3; bus2.b_rd_addr = 1'd1;
        @(negedge clk);
        chk("w16_w3", bus2.w_rd_data, 16'hDEF0);
        chk("w16_b1", bus2.b_rd_data, 16'h7FFF);
        bus2.w_rd_addr = 2'd0; bus2.b_rd_addr = 1'd0;
        @(negedge clk);
        chk("w16_w0", bus2.w_rd_data, 16'h1234);
        chk("w16_b0", bus2.b_rd_data, 16'h8001);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit, required finish");
        $fatal(1);
    end

    initial begin
        bus.rx_data = '0; bus.rx_ready = 1'b0; bus.rearm = 1'b0;
        bus.w_rd_addr = '0; bus.b_rd_addr = '0;
        bus2.rx_data = '0; bus2.rx_ready = 1'b0; bus2.rearm = 1'b0;
        bus2.w_rd_addr = '0; bus2.b_rd_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0; rst2 = 1'b0;
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_done_pulse", bus.done_pulse, 0);
        chk("reset_err", bus.err, 0);
        chk("reset_byte_cnt", bus.byte_cnt, 0);
        mon_en = 1'b1;

        // Directed load with known weights and biases
        for (int i = 0; i < N_W; i++) pay[i] = 8'(i + 1);
        pay[8] = 8'h10; pay[9] = 8'h00; pay[10] = 8'h00; pay[11] = 8'h00;
        pay[12] = 8'hF0; pay[13] = 8'hFF; pay[14] = 8'hFF; pay[15] = 8'hFF;
        mk_stream(psum(), 8'h55, 8'hAA);
        run();
        chk("t1_done", bus.done, 1);
        chk("t1_done_pulse_low", bus.done_pulse, 0);
        chk("t1_busy", bus.busy, 0);
        read_all();
        bus.w_rd_addr = 3'd5; bus.b_rd_addr = 1'd1; rd_req = 1'b1;
        rd_q.push_back(rd_t'{8'h06, 32'hFFFFFFF0});
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);

        // Tail pattern inside payload must not end the load
        do_rearm(0);
        rand_pay(); pay[2] = 8'h55; pay[3] = 8'hAA;
        mk_stream(psum(), 8'h55, 8'hAA);
        run();
        chk("t2_done", bus.done, 1);
        read_all();

        // Checksum off by one, trailing bytes ignored
        do_rearm(0);
        rand_pay();
        mk_stream(psum() + 8'd1, 8'h55, 8'hAA);
        for (int i = 0; i < 3; i++) str.push_back(8'($urandom));
        run();
        chk("t3_err", bus.err, 1);
        chk("t3_done", bus.done, 0);
        chk("t3_busy", bus.busy, 0);
        chk("t3_byte_cnt", bus.byte_cnt, PAYLOAD);
        read_all();

        // Bad tail, then rearm coinciding with a byte, then a good transfer
        do_rearm(0);
        rand_pay();
        mk_stream(psum(), 8'h55, 8'h00);
        run();
        chk("t4_err", bus.err, 2);
        chk("t4_done", bus.done, 0);
        do_rearm(1);
        rand_pay();
        mk_stream(psum(), 8'h55, 8'hAA);
        run();
        chk("t4_reload_done", bus.done, 1);
        chk("t4_reload_err", bus.err, 0);
        read_all();

        // Timeout exactly TMO cycles after the last strobe
        do_rearm(0);
        rand_pay();
        mk_stream(psum(), 8'h55, 8'hAA);
        while (str.size() > SKIP + 7) str.pop_back();
        model_push();
        foreach (str[i]) send(str[i], $urandom_range(3, 0));
        repeat (TMO - 1) @(negedge clk);
        chk("t5_err_before", bus.err, 0);
        chk("t5_busy_before", bus.busy, 1);
        @(negedge clk);
        chk("t5_err_timeout", bus.err, 3);
        chk("t5_byte_cnt", bus.byte_cnt, 7);
        chk("t5_busy_after", bus.busy, 0);
        read_all();

        // Random transfers
        for (int t = 0; t < 3; t++) begin
            do_rearm(t[0]);
            rand_pay();
            mk_stream(psum(), 8'h55, 8'hAA);
            run();
            read_all();
        end

        test_wide();

        repeat (5) @(negedge clk);
        chk("event_queue_empty", ev_q.size(), 0);
        chk("read_queue_empty", rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
